// File: rtl/uart_tx_arbiter_if.sv
// Requester, PHY and status signals of the UART TX arbiter.
// slave = arbiter side, master = requesters/PHY/divider side.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int GW = $clog2(NUM_REQ);

   logic                        baud_tick;
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ*DATA_W-1:0]   req_data;
   logic [NUM_REQ-1:0]          req_ready;
   logic                        phy_start;
   logic [DATA_W-1:0]           phy_data;
   logic                        phy_busy;
   logic [GW-1:0]               grant_id;
   logic                        arb_busy;

   modport slave (
      input  baud_tick, req_valid, req_data, phy_busy,
      output req_ready, phy_start, phy_data, grant_id, arb_busy
   );

   modport master (
      output baud_tick, req_valid, req_data, phy_busy,
      input  req_ready, phy_start, phy_data, grant_id, arb_busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX PHY among NUM_REQ byte requesters,
// with a baud-tick counted idle gap between frames.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for a request while the PHY is idle; picks winner
// S_ACCEPT    | req_ready pulsed to the winner; byte captured if still valid
// S_LAUNCH    | phy_start pulsed with the captured byte
// S_WAIT_BUSY | waiting up to 2 cycles for the PHY to report busy
// S_WAIT_DONE | PHY transmitting; waiting for busy to drop
// S_GAP       | idle gap, counts GAP_TICKS baud ticks down to zero
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int GAP_TICKS = 2
) (
   input logic               sys_clk,
   input logic               reset_n,
   uart_tx_arbiter_if.slave  bus
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS);
   localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       last_q, last_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [NUM_REQ-1:0]  ready_q, ready_d;
   logic                start_q, start_d;
   logic [CW-1:0]       gap_q, gap_d;
   logic                wb_q, wb_d;

   logic                win_found;
   logic [GW-1:0]       win_idx;
   logic [GW-1:0]       cand;
   logic [DATA_W-1:0]   req_bytes [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = bus.req_data[gi*DATA_W +: DATA_W];
   end

   // search starts one past the last completed grant and wraps
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = GW'((int'(last_q) + i) % NUM_REQ);
         if (!win_found && bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      data_d  = data_q;
      ready_d = '0;
      start_d = 1'b0;
      gap_d   = gap_q;
      wb_d    = wb_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_found && !bus.phy_busy) begin
               grant_d          = win_idx;
               ready_d[win_idx] = 1'b1;
               state_d          = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            // a withdrawn request leaves the pointer alone so nobody loses a turn
            if (bus.req_valid[grant_q]) begin
               data_d  = req_bytes[grant_q];
               last_d  = grant_q;
               start_d = 1'b1;
               state_d = S_LAUNCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            wb_d    = 1'b1;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.phy_busy) begin
               state_d = S_WAIT_DONE;
            end else if (wb_q == 1'b0) begin
               gap_d   = GAP_LOAD;
               state_d = S_GAP;
            end else begin
               wb_d = wb_q - 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.phy_busy) begin
               gap_d   = GAP_LOAD;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_IDLE;
            end else if (bus.baud_tick) begin
               gap_d = gap_q - 1'b1;
               if (gap_q == CW'(1)) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= LAST_INIT;
         data_q  <= '0;
         ready_q <= '0;
         start_q <= 1'b0;
         gap_q   <= '0;
         wb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         start_q <= start_d;
         gap_q   <= gap_d;
         wb_q    <= wb_d;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.phy_start = start_q;
   assign bus.phy_data  = data_q;
   assign bus.grant_id  = grant_q;
   assign bus.arb_busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4 requesters, 8-bit data, GAP_TICKS=2,
// with a behavioural PHY (busy for 10 cycles after start) and baud tick source.
module tb_uart_tx_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int   tick_period = 0;
   int   tick_cnt    = 0;
   logic gen_tick    = 1'b0;
   logic man_tick    = 1'b0;
   logic phy_mode    = 1'b1;
   int   busy_cnt    = 0;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

   assign bus.baud_tick = gen_tick | man_tick;

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .GAP_TICKS(2)) dut (
      .sys_clk (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // baud divider model: one-cycle pulse every tick_period cycles (0 = off)
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tick_period == 0) begin
            gen_tick = 1'b0;
            tick_cnt = 0;
         end else begin
            tick_cnt++;
            if (tick_cnt >= tick_period) begin
               tick_cnt = 0;
               gen_tick = 1'b1;
            end else begin
               gen_tick = 1'b0;
            end
         end
      end
   end

   // PHY model: busy in the launch cycle and the 9 cycles after it
   initial begin
      bus.phy_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.phy_start && phy_mode) begin
            bus.phy_busy = 1'b1;
            busy_cnt     = 10;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.phy_busy = 1'b0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_byte(input int i, input logic [DW-1:0] v);
      bus.req_data[i*DW +: DW] = v;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((bus.arb_busy !== 1'b0 || bus.phy_busy !== 1'b0) && n < 300) begin
         cyc();
         n++;
      end
      checks++; if (n >= 300) begin errors++; $display("FAIL %s_idle: arb_busy=%b after %0d cycles, expected 0", name, bus.arb_busy, n); end
   endtask

   task automatic do_reset();
      cyc();
      rst_n = 1'b0;
      bus.req_valid = '0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      repeat (3) cyc();
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
      checks++; if (bus.phy_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", bus.phy_start); end
      checks++; if (bus.phy_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.phy_data); end
      checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_id); end
      checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.arb_busy); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      int launches;
      tick_period = 4;
      phy_mode    = 1'b1;
      set_byte(2, 8'hA5);
      bus.req_valid = 4'b0100;
      cyc();
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
      checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant got=%0d exp=2", bus.grant_id); end
      checks++; if (bus.arb_busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus.arb_busy); end
      cyc();
      checks++; if (bus.phy_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", bus.phy_start); end
      checks++; if (bus.phy_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", bus.phy_data); end
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_drop got=%b exp=0000", bus.req_ready); end
      bus.req_valid = '0;
      launches = 0;
      repeat (60) begin
         cyc();
         if (bus.phy_start) launches++;
      end
      checks++; if (launches != 0) begin errors++; $display("FAIL single_extra_launch got=%0d exp=0", launches); end
      wait_idle("single");
   endtask

   task automatic test_contention();
      int exp_g [6];
      logic [7:0] exp_d [6];
      int g_seq [6];
      logic [7:0] d_seq [6];
      int n_launch, cycles, viol;
      logic [NR-1:0] prev_ready;
      logic prev_start;
      exp_g = '{0, 1, 2, 3, 0, 1};
      exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
      do_reset();
      tick_period = 4;
      for (int i = 0; i < NR; i++) set_byte(i, 8'(8'h10 + i));
      bus.req_valid = 4'b1111;
      n_launch = 0; cycles = 0; viol = 0;
      prev_ready = '0; prev_start = 1'b0;
      while (n_launch < 6 && cycles < 1000) begin
         cyc();
         cycles++;
         if ($countones(bus.req_ready) > 1) viol++;
         if (bus.req_ready != '0 && prev_ready != '0) viol++;
         if (bus.phy_start && prev_start) viol++;
         if (bus.phy_start) begin
            g_seq[n_launch] = int'(bus.grant_id);
            d_seq[n_launch] = bus.phy_data;
            n_launch++;
         end
         prev_ready = bus.req_ready;
         prev_start = bus.phy_start;
      end
      bus.req_valid = '0;
      checks++; if (n_launch != 6) begin errors++; $display("FAIL cont_launches got=%0d exp=6", n_launch); end
      for (int i = 0; i < n_launch; i++) begin
         checks++; if (g_seq[i] != exp_g[i]) begin errors++; $display("FAIL cont_grant[%0d] got=%0d exp=%0d", i, g_seq[i], exp_g[i]); end
         checks++; if (d_seq[i] !== exp_d[i]) begin errors++; $display("FAIL cont_data[%0d] got=%h exp=%h", i, d_seq[i], exp_d[i]); end
      end
      checks++; if (viol != 0) begin errors++; $display("FAIL cont_pulse_rules got=%0d violations exp=0", viol); end
      wait_idle("cont");
   endtask

   task automatic test_back_to_back();
      int n, ticks, early;
      tick_period = 16;
      set_byte(0, 8'h21);
      set_byte(3, 8'h24);
      bus.req_valid = 4'b1001;
      n = 0;
      while (bus.phy_start !== 1'b1 && n < 100) begin cyc(); n++; end
      checks++; if (n >= 100) begin errors++; $display("FAIL b2b_first_start got=timeout exp=launch"); end
      checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL b2b_first_grant got=%0d exp=3", bus.grant_id); end
      checks++; if (bus.phy_data !== 8'h24) begin errors++; $display("FAIL b2b_first_data got=%h exp=24", bus.phy_data); end
      bus.req_valid = 4'b0001;
      n = 0;
      while (bus.phy_busy !== 1'b1 && n < 50) begin cyc(); n++; end
      while (bus.phy_busy !== 1'b0 && n < 100) begin cyc(); n++; end
      checks++; if (n >= 100) begin errors++; $display("FAIL b2b_busy_fall got=timeout exp=fall"); end
      ticks = 0; early = 0; n = 0;
      while (ticks < 2 && n < 100) begin
         cyc();
         n++;
         if (bus.phy_start) early++;
         if (bus.baud_tick) ticks++;
      end
      checks++; if (ticks != 2) begin errors++; $display("FAIL b2b_ticks got=%0d exp=2", ticks); end
      repeat (2) begin
         cyc();
         if (bus.phy_start) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL b2b_early_start got=%0d exp=0", early); end
      cyc();
      checks++; if (bus.phy_start !== 1'b1) begin errors++; $display("FAIL b2b_second_start got=%b exp=1", bus.phy_start); end
      checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL b2b_second_grant got=%0d exp=0", bus.grant_id); end
      checks++; if (bus.phy_data !== 8'h21) begin errors++; $display("FAIL b2b_second_data got=%h exp=21", bus.phy_data); end
      bus.req_valid = '0;
      wait_idle("b2b");
   endtask

   task automatic test_withdraw();
      tick_period = 4;
      set_byte(1, 8'h61);
      set_byte(3, 8'h63);
      bus.req_valid = 4'b1010;
      cyc();
      checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wd_ready1 got=%b exp=0010", bus.req_ready); end
      checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL wd_grant1 got=%0d exp=1", bus.grant_id); end
      bus.req_valid = 4'b1000;
      cyc();
      checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL wd_back_idle got=%b exp=0", bus.arb_busy); end
      checks++; if (bus.phy_start !== 1'b0) begin errors++; $display("FAIL wd_no_start got=%b exp=0", bus.phy_start); end
      cyc();
      checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wd_ready3 got=%b exp=1000", bus.req_ready); end
      checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL wd_grant3 got=%0d exp=3", bus.grant_id); end
      cyc();
      checks++; if (bus.phy_start !== 1'b1) begin errors++; $display("FAIL wd_start3 got=%b exp=1", bus.phy_start); end
      checks++; if (bus.phy_data !== 8'h63) begin errors++; $display("FAIL wd_data3 got=%h exp=63", bus.phy_data); end
      bus.req_valid = '0;
      wait_idle("wd");
   endtask

   task automatic test_no_response();
      tick_period = 0;
      phy_mode    = 1'b0;
      set_byte(2, 8'h3C);
      bus.req_valid = 4'b0100;
      cyc();
      checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL nr_ready got=%b exp=0100", bus.req_ready); end
      cyc();
      checks++; if (bus.phy_start !== 1'b1 || bus.phy_data !== 8'h3C) begin errors++; $display("FAIL nr_start got=%b/%h exp=1/3c", bus.phy_start, bus.phy_data); end
      bus.req_valid = '0;
      cyc();
      cyc();
      man_tick = 1'b1;
      checks++; if (bus.arb_busy !== 1'b1) begin errors++; $display("FAIL nr_busy_wait got=%b exp=1", bus.arb_busy); end
      cyc();
      cyc();
      checks++; if (bus.arb_busy !== 1'b1) begin errors++; $display("FAIL nr_busy_gap got=%b exp=1", bus.arb_busy); end
      cyc();
      man_tick = 1'b0;
      checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL nr_gap_exit got=%b exp=0", bus.arb_busy); end
      phy_mode    = 1'b1;
      tick_period = 4;
      set_byte(0, 8'h77);
      bus.req_valid = 4'b0001;
      cyc();
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL nr_next_ready got=%b exp=0001", bus.req_ready); end
      cyc();
      checks++; if (bus.phy_start !== 1'b1 || bus.phy_data !== 8'h77) begin errors++; $display("FAIL nr_next_start got=%b/%h exp=1/77", bus.phy_start, bus.phy_data); end
      bus.req_valid = '0;
      wait_idle("nr");
   endtask

   task automatic test_reset_mid();
      int n;
      tick_period = 4;
      for (int i = 0; i < NR; i++) set_byte(i, 8'(8'h10 + i));
      bus.req_valid = 4'b1111;
      n = 0;
      while (bus.phy_start !== 1'b1 && n < 100) begin cyc(); n++; end
      checks++; if (n >= 100 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL rm_pre_grant got=%0d exp=1", bus.grant_id); end
      repeat (5) cyc();
      rst_n = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready got=%b exp=0000", bus.req_ready); end
      checks++; if (bus.phy_start !== 1'b0) begin errors++; $display("FAIL rm_start got=%b exp=0", bus.phy_start); end
      checks++; if (bus.phy_data !== 8'h00) begin errors++; $display("FAIL rm_data got=%h exp=00", bus.phy_data); end
      checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rm_grant got=%0d exp=0", bus.grant_id); end
      checks++; if (bus.arb_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", bus.arb_busy); end
      repeat (2) cyc();
      rst_n = 1'b1;
      n = 0;
      while (bus.req_ready === 4'b0000 && n < 100) begin cyc(); n++; end
      checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_ready got=%b exp=0001", bus.req_ready); end
      checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rm_first_grant got=%0d exp=0", bus.grant_id); end
      cyc();
      checks++; if (bus.phy_start !== 1'b1 || bus.phy_data !== 8'h10) begin errors++; $display("FAIL rm_first_start got=%b/%h exp=1/10", bus.phy_start, bus.phy_data); end
      bus.req_valid = '0;
      wait_idle("rm");
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_withdraw();
      test_no_response();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
